// File: rtl/image_pkg.sv
// Shared defaults and types for the image frame writer and its frame RAM.
package image_pkg;

   localparam int unsigned PIX_W_DEFAULT    = 3;
   localparam int unsigned DIM_LOG2_DEFAULT = 8;

   typedef logic [PIX_W_DEFAULT-1:0] pixel_t;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StClear,
      StDone
   } fw_state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read-before-write read port.
module frame_ram
   import image_pkg::*;
#(
   parameter int unsigned ADDR_W = 2 * DIM_LOG2_DEFAULT,
   parameter int unsigned DATA_W = PIX_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // The array is deliberately left out of reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/image_frame_writer.sv
// Raster-order frame writer into an internal frame RAM with an independent read port.
// Optional background-fill mode is built when FRAME_WRITER_CLEAR_EN is defined.
module image_frame_writer
   import image_pkg::*;
#(
   parameter int unsigned PIX_W    = PIX_W_DEFAULT,
   parameter int unsigned DIM_LOG2 = DIM_LOG2_DEFAULT,
   parameter int unsigned BG_PIXEL = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                clear,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [PIX_W-1:0]    s_pixel,
   output logic                busy,
   output logic                frame_done,
   output logic [DIM_LOG2-1:0] wr_row,
   output logic [DIM_LOG2-1:0] wr_col,
   input  logic [DIM_LOG2-1:0] rd_row,
   input  logic [DIM_LOG2-1:0] rd_col,
   output logic [PIX_W-1:0]    rd_pixel
);

   localparam int unsigned ADDR_W = 2 * DIM_LOG2;

   fw_state_t           r_state;
   fw_state_t           w_state_d;
   logic [DIM_LOG2-1:0] r_wr_row;
   logic [DIM_LOG2-1:0] r_wr_col;
   logic [DIM_LOG2-1:0] w_row_d;
   logic [DIM_LOG2-1:0] w_col_d;
   logic                r_frame_done;
   logic                w_we;
   logic [PIX_W-1:0]    w_wdata;
   logic [ADDR_W-1:0]   w_addr;
   logic [ADDR_W-1:0]   w_addr_inc;
   logic                w_last;

`ifdef FRAME_WRITER_CLEAR_EN
   localparam logic [PIX_W-1:0] BG_VALUE = PIX_W'(BG_PIXEL);
`else
   logic                w_unused_clear;
   logic [PIX_W-1:0]    w_unused_bg;

   assign w_unused_clear = clear;
   assign w_unused_bg    = PIX_W'(BG_PIXEL);
`endif

   assign w_addr     = {r_wr_row, r_wr_col};
   assign w_addr_inc = w_addr + ADDR_W'(1);
   assign w_last     = &w_addr;

   always_comb begin
      w_state_d = r_state;
      w_row_d   = r_wr_row;
      w_col_d   = r_wr_col;
      w_we      = 1'b0;
      w_wdata   = s_pixel;

      unique case (r_state)
         StIdle: begin
            w_row_d = '0;
            w_col_d = '0;
            if (start) begin
               w_state_d = StWrite;
            end
`ifdef FRAME_WRITER_CLEAR_EN
            // Clear overrides a simultaneous start.
            if (clear) begin
               w_state_d = StClear;
            end
`endif
         end

         StWrite: begin
            if (s_valid) begin
               w_we               = 1'b1;
               {w_row_d, w_col_d} = w_addr_inc;
               if (w_last) begin
                  w_state_d = StDone;
               end
            end
         end

`ifdef FRAME_WRITER_CLEAR_EN
         StClear: begin
            w_we               = 1'b1;
            w_wdata            = BG_VALUE;
            {w_row_d, w_col_d} = w_addr_inc;
            if (w_last) begin
               w_state_d = StDone;
            end
         end
`endif

         StDone: begin
            w_row_d   = '0;
            w_col_d   = '0;
            w_state_d = StIdle;
         end

         default: begin
            w_row_d   = '0;
            w_col_d   = '0;
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_wr_row     <= '0;
         r_wr_col     <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_wr_row     <= w_row_d;
         r_wr_col     <= w_col_d;
         r_frame_done <= (w_state_d == StDone);
      end
   end

   assign s_ready    = (r_state == StWrite);
   assign busy       = (r_state != StIdle);
   assign frame_done = r_frame_done;
   assign wr_row     = r_wr_row;
   assign wr_col     = r_wr_col;

   frame_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (PIX_W)
   ) u_frame_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (w_addr),
      .i_wdata (w_wdata),
      .i_raddr ({rd_row, rd_col}),
      .o_rdata (rd_pixel)
   );

endmodule

// File: tb/tb_image_frame_writer.sv
// Randomized self-checking bench for image_frame_writer on a 16x16 image.
module tb_image_frame_writer;

   localparam int unsigned PW   = 3;
   localparam int unsigned DL   = 4;
   localparam int unsigned BG   = 4;
   localparam int unsigned SIDE = 16;
   localparam int unsigned NPIX = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          clear;
   logic          s_valid;
   logic          s_ready;
   logic [PW-1:0] s_pixel;
   logic          busy;
   logic          frame_done;
   logic [DL-1:0] wr_row;
   logic [DL-1:0] wr_col;
   logic [DL-1:0] rd_row;
   logic [DL-1:0] rd_col;
   logic [PW-1:0] rd_pixel;

   int unsigned model [NPIX];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   image_frame_writer #(
      .PIX_W    (PW),
      .DIM_LOG2 (DL),
      .BG_PIXEL (BG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .clear      (clear),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_pixel    (s_pixel),
      .busy       (busy),
      .frame_done (frame_done),
      .wr_row     (wr_row),
      .wr_col     (wr_col),
      .rd_row     (rd_row),
      .rd_col     (rd_col),
      .rd_pixel   (rd_pixel)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int unsigned addr);
      rd_row = DL'(addr / SIDE);
      rd_col = DL'(addr % SIDE);
   endtask

   task automatic read_check(input string tag, input int unsigned addr);
      set_rd(addr);
      tick();
      check_eq(tag, 32'(rd_pixel), model[addr]);
   endtask

   // pattern: pixel = index mod 8; stall_pct: chance (%) of an idle stream cycle.
   task automatic run_frame(input bit pattern, input int unsigned stall_pct, input bit rdchk);
      int unsigned k      = 0;
      int unsigned cycles = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("start_busy", 32'(busy), 1);
      check_eq("start_ready", 32'(s_ready), 1);
      while (k < NPIX && cycles < 4 * NPIX + 64) begin
         bit          v;
         int unsigned pix;
         int unsigned ra;
         int unsigned exp_rd;
         v = ($urandom_range(99) >= stall_pct);
         if (stall_pct > 0 && cycles < 8) v = (cycles % 2 == 0);
         pix = pattern ? (k % 8) : $urandom_range(7);
         ra  = ($urandom_range(1) == 1) ? k : $urandom_range(NPIX - 1);
         set_rd(ra);
         exp_rd  = model[ra];
         s_valid = v;
         s_pixel = PW'(pix);
         if (v) begin
            model[k] = pix;
            k++;
         end
         tick();
         cycles++;
         if (rdchk) check_eq("rd_before_write", 32'(rd_pixel), exp_rd);
         if (k < NPIX) begin
            check_eq("wr_row", 32'(wr_row), k / SIDE);
            check_eq("wr_col", 32'(wr_col), k % SIDE);
            check_eq("frame_done_early", 32'(frame_done), 0);
         end
      end
      s_valid = 1'b0;
      check_eq("frame_timeout", k, NPIX);
      check_eq("frame_done", 32'(frame_done), 1);
      check_eq("done_busy", 32'(busy), 1);
      check_eq("done_ready", 32'(s_ready), 0);
      check_eq("done_row", 32'(wr_row), 0);
      check_eq("done_col", 32'(wr_col), 0);
      if (stall_pct == 0) check_eq("frame_cycles", cycles, NPIX);
      // A start raised during the done cycle must be dropped.
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("done_pulse", 32'(frame_done), 0);
      check_eq("idle_after_done", 32'(busy), 0);
      tick();
      check_eq("start_in_done_lost", 32'(busy), 0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      clear   = 1'b0;
      s_valid = 1'b0;
      s_pixel = '0;
      rd_row  = '0;
      rd_col  = '0;
      tick();
      tick();
      check_eq("rst_ready", 32'(s_ready), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(frame_done), 0);
      check_eq("rst_row", 32'(wr_row), 0);
      check_eq("rst_col", 32'(wr_col), 0);
      check_eq("rst_rd", 32'(rd_pixel), 0);
      rst = 1'b0;
      tick();
      check_eq("idle_busy", 32'(busy), 0);

      // Pattern frame, no stalls.
      run_frame(1'b1, 0, 1'b0);
      set_rd(3 * SIDE + 5);
      tick();
      check_eq("rd_3_5", 32'(rd_pixel), 5);
      set_rd(NPIX - 1);
      tick();
      check_eq("rd_15_15", 32'(rd_pixel), 7);
      for (int i = 0; i < 16; i++) read_check("rd_rand_a", $urandom_range(NPIX - 1));

      // Random data with stalls and collision reads.
      run_frame(1'b0, 40, 1'b1);
      for (int i = 0; i < 16; i++) read_check("rd_rand_b", $urandom_range(NPIX - 1));

      // Reset part-way through a frame.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         int unsigned pix;
         pix      = $urandom_range(7);
         model[i] = pix;
         s_valid  = 1'b1;
         s_pixel  = PW'(pix);
         tick();
      end
      s_valid = 1'b0;
      rst     = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_busy", 32'(busy), 0);
      check_eq("midrst_ready", 32'(s_ready), 0);
      check_eq("midrst_row", 32'(wr_row), 0);
      check_eq("midrst_col", 32'(wr_col), 0);
      check_eq("midrst_rd", 32'(rd_pixel), 0);
      read_check("midrst_keep_1_3", 1 * SIDE + 3);
      run_frame(1'b0, 20, 1'b1);

`ifdef FRAME_WRITER_CLEAR_EN
      begin
         int unsigned n = 0;
         start   = 1'b1;
         clear   = 1'b1;
         s_valid = 1'b1;
         tick();
         start = 1'b0;
         clear = 1'b0;
         check_eq("clear_busy", 32'(busy), 1);
         check_eq("clear_wins", 32'(s_ready), 0);
         while (frame_done !== 1'b1 && n < 400) begin
            tick();
            n++;
            check_eq("clear_ready", 32'(s_ready), 0);
         end
         s_valid = 1'b0;
         check_eq("clear_cycles", n, NPIX);
         for (int i = 0; i < NPIX; i++) model[i] = BG;
         tick();
         check_eq("clear_idle", 32'(busy), 0);
         for (int i = 0; i < NPIX; i++) read_check("clear_fill", i);
      end
`else
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_eq("clear_ignored", 32'(busy), 0);
      tick();
      check_eq("clear_ignored_2", 32'(busy), 0);
      read_check("clear_no_fill", $urandom_range(NPIX - 1));
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
